// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
// LSB first. A single full-adder cell sums a[i], ~b[i] and a registered carry
// that is preset to 1, so the datapath computes a + ~b + 1.
//
// Handshake:
//   - start is sampled on a rising edge while the block is IDLE or DONE.
//     That edge latches a and b.
//   - busy is high for the WIDTH cycles in which bits are processed.
//   - done pulses for one cycle once diff/borrow/ovf hold the new result.
//   - With start held high, a new operation begins every WIDTH+1 cycles.
//
// Result outputs change only on the transition into DONE. During RUN they
// keep showing the previous result.
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  // -------------------------------------------------------------------------
  // Local types and constants
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The counter only needs to reach WIDTH-1 (index of the MSB being processed).
  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_next;

  logic [WIDTH-1:0]   r_a_sh;     // minuend, shifted right one bit per RUN edge
  logic [WIDTH-1:0]   r_b_sh;     // subtrahend, shifted right one bit per RUN edge
  logic               r_carry;    // carry into the bit currently being processed
  logic [CNT_W-1:0]   r_cnt;      // index of the bit currently being processed
  logic [WIDTH-2:0]   r_res;      // difference bits collected so far, newest at top

  // -------------------------------------------------------------------------
  // Combinational datapath signals
  // -------------------------------------------------------------------------
  logic               w_accept;   // this edge latches a new operation
  logic               w_running;  // this edge processes one operand bit
  logic               w_last;     // this edge processes bit WIDTH-1
  logic               w_a_bit;    // current minuend bit
  logic               w_nb_bit;   // current inverted subtrahend bit
  logic               w_sum;      // full-adder sum for the current bit
  logic               w_cout;     // full-adder carry-out for the current bit
  logic [WIDTH-1:0]   w_res_cat;  // new sum bit joined with the collected bits

  // Start is honoured only when no subtraction is in flight.
  assign w_accept  = start && (r_state != ST_RUN);
  assign w_running = (r_state == ST_RUN);
  assign w_last    = w_running && (r_cnt == CNT_LAST);

  // One full-adder cell computing a + ~b + carry.
  assign w_a_bit   = r_a_sh[0];
  assign w_nb_bit  = ~r_b_sh[0];
  assign w_sum     = w_a_bit ^ w_nb_bit ^ r_carry;
  assign w_cout    = (w_a_bit & w_nb_bit) | (w_a_bit & r_carry) | (w_nb_bit & r_carry);

  // When the MSB sum is placed on top of the WIDTH-1 collected bits, the
  // result is complete. Bit 0 of the concatenation is the LSB of the
  // difference.
  assign w_res_cat = {w_sum, r_res};

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // Hold the control state; the asynchronous reset returns to IDLE from anywhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so that every
      // register samples pre-edge values, regardless of block ordering.
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // Decide where the handshake goes on the next edge.
  always_comb begin
    // NOTE: a default assignment first keeps every path assigned, so no latch
    // is inferred when a case branch leaves the state unchanged.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Back-to-back start skips IDLE so a held start repeats every WIDTH+1 cycles.
        if (start) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output decode
  // -------------------------------------------------------------------------
  // Derive busy/done directly from the state so they are glitch-free registers' decodes.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Serial datapath
  // -------------------------------------------------------------------------
  // Latch operands on accept, then process one bit per edge while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      // Carry-in of 1 completes the two's-complement negation of b.
      r_carry <= 1'b1;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (w_running) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      r_res   <= w_res_cat[WIDTH-1:1];
    end
  end

  // -------------------------------------------------------------------------
  // Result registers
  // -------------------------------------------------------------------------
  // Publish diff and flags only on the edge that finishes the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else if (w_last) begin
      diff   <= w_res_cat;
      // Carry-out of a + ~b + 1 is the inverse of the unsigned borrow.
      borrow <= ~w_cout;
      // r_carry is the carry into the MSB on this edge; signed overflow is
      // the disagreement between carry-in and carry-out of the sign bit.
      ovf    <= r_carry ^ w_cout;
    end
  end

endmodule
